xor_share_arb: RTL and testbench
================================

XOR_SHARE_ARB -- requirements
Module: xor_share_arb

Interface
REQ-001 Parameter SETTLE, default 3, SHALL set the number of clock cycles the shared XOR datapath is given to settle (legal 1..15).
REQ-002 Parameter W, default 8, SHALL set the operand/result width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  4  SHALL carry per-requester request lines, bit i = requester i.
REQ-006 a0..a3  input  W each  SHALL carry operand A of requester i.
REQ-007 b0..b3  input  W each  SHALL carry operand B of requester i.
REQ-008 gnt  output  4  SHALL be the one-hot grant, or all zero when no operation is active.
REQ-009 done  output  4  SHALL be a one-hot, single-cycle completion pulse to the granted requester.
REQ-010 result  output  W  SHALL hold the XOR result of the most recently completed operation.
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SETTLE, DONE.
REQ-013 In IDLE with req != 0, the next edge SHALL: select the winner, set gnt to its one-hot code, latch a_w/b_w into internal operand registers, load counter with SETTLE, and enter SETTLE.
REQ-014 In IDLE with req == 0, state, gnt and operand registers SHALL hold.
REQ-015 Arbitration SHALL be round-robin: search starts at index (ptr+1) mod 4 and wraps upward; ptr updates to the winner index on grant.
REQ-016 In SETTLE, each edge SHALL decrement the counter; the edge on which the counter equals 1 SHALL enter DONE instead.
REQ-017 On entry to DONE, result SHALL be loaded with op_a ^ op_b, and done SHALL equal gnt for exactly that one cycle.
REQ-018 Latency SHALL be exactly SETTLE cycles from gnt rising to done rising: 3 cycles for default SETTLE.
REQ-019 DONE SHALL return to IDLE on the next edge, clearing gnt and done; a new grant earliest one cycle later, giving a throughput of one operation per SETTLE+2 cycles.
REQ-020 Operands SHALL be sampled only at grant; operand changes during SETTLE SHALL NOT affect result.
REQ-021 Deasserting the granted req during SETTLE/DONE SHALL NOT abort the operation; done still pulses.
REQ-022 A requester SHALL keep req high until it sees its done bit; req still high in IDLE after done is treated as a new request.
REQ-023 New or changing requests during SETTLE/DONE SHALL be ignored until IDLE.
REQ-024 result SHALL hold its value from one DONE entry until the next DONE entry.
REQ-025 gnt and done SHALL never have more than one bit set.

Reset
REQ-026 With reset high at an edge, state SHALL become IDLE, and gnt=0, done=0, busy=0, result=0, counter=0, ptr=3 (requester 0 highest priority first).
REQ-027 Reset SHALL override any state, including mid-SETTLE: the pending operation is discarded and no done pulse is produced.
REQ-028 Reset SHALL take priority over a simultaneous request.

Verification
REQ-029 Single op: after reset, req=0001, a0=8'hA5, b0=8'h0F -> gnt=0001 next cycle; done=0001 and result=8'hAA exactly 3 cycles later; gnt=0 the following cycle.
REQ-030 Round-robin: req=1111 held continuously from reset -> grants in the order 0001, 0010, 0100, 1000, 0001, each separated by SETTLE+2=5 cycles.
REQ-031 Operand isolation: grant requester 2 with a2=8'hFF, b2=8'h00, then change a2 to 8'h00 during SETTLE -> result=8'hFF.
REQ-032 Reset mid-op: assert reset while the counter equals 2 -> the next cycle gnt=0, busy=0, result=0, and no done pulse for that operation.
REQ-033 Drop request: requester 3 granted, req deasserted to 0000 the cycle after the grant -> done=1000 still pulses at +3 cycles; afterwards stays IDLE.
REQ-034 Identity: a1=b1=8'h3C -> result=8'h00; SETTLE=1 build -> done one cycle after gnt.

Source files
------------

// File: rtl/xor_share_arb.sv
// Four requesters share one XOR datapath through a round-robin arbiter.
// Each grant latches that requester's operands and waits SETTLE cycles before the result is posted.
module xor_share_arb #(
    parameter int SETTLE = 3,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] b1,
    input  logic [W-1:0] b2,
    input  logic [W-1:0] b3,
    output logic [3:0]   gnt,
    output logic [3:0]   done,
    output logic [W-1:0] result,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [W-1:0]   result_q, result_d;

    logic [2:0]     pick;
    logic [1:0]     win;
    logic [W-1:0]   a_w, b_w;

    // Returns {found, index}; the search starts one past the last winner and wraps.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (r[idx] && !rr_pick[2]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    assign pick = rr_pick(req, ptr_q);
    assign win  = pick[1:0];

    always_comb begin
        a_w = a0;
        b_w = b0;
        case (win)
            2'd0: begin a_w = a0; b_w = b0; end
            2'd1: begin a_w = a1; b_w = b1; end
            2'd2: begin a_w = a2; b_w = b2; end
            default: begin a_w = a3; b_w = b3; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (pick[2]) begin
                    gnt_d   = 4'b0001 << win;
                    ptr_d   = win;
                    op_a_d  = a_w;
                    op_b_d  = b_w;
                    cnt_d   = 4'(SETTLE);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd1) begin
                    result_d = op_a_q ^ op_b_q;
                    cnt_d    = 4'd0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                gnt_d   = 4'b0000;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= 4'b0000;
            cnt_q    <= 4'd0;
            ptr_q    <= 2'd3;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
        end
    end

    // Operand registers only change on a grant, so they need no reset.
    always_ff @(posedge clk) begin
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
    end

    assign gnt    = gnt_q;
    assign done   = (state_q == S_DONE) ? gnt_q : 4'b0000;
    assign result = result_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed bench for xor_share_arb: default build plus a SETTLE=1 build sharing reset and operands.
module tb_xor_share_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, req1;
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [3:0] gnt, done, gnt1, done1;
    logic [7:0] result, result1;
    logic       busy, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_share_arb #(.SETTLE(3), .W(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .gnt(gnt), .done(done), .result(result), .busy(busy)
    );

    xor_share_arb #(.SETTLE(1), .W(8)) dut1 (
        .clk(clk), .reset(reset), .req(req1),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .gnt(gnt1), .done(done1), .result(result1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rr_gnt [5];
    logic [7:0] rr_res [5];

    initial begin
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_res = '{8'hAA, 8'h00, 8'hFF, 8'h26, 8'hAA};

        reset = 1'b1; req = 4'b0000; req1 = 4'b0000;
        a0 = 8'hA5; b0 = 8'h0F; a1 = 8'h3C; b1 = 8'h3C;
        a2 = 8'hFF; b2 = 8'h00; a3 = 8'h12; b3 = 8'h34;
        tick(); tick();
        check("rst_gnt", {4'b0, gnt}, 8'h00);
        check("rst_done", {4'b0, done}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_result", result, 8'h00);

        // Single operation from requester 0
        reset = 1'b0; req = 4'b0001;
        tick();
        check("single_gnt", {4'b0, gnt}, 8'h01);
        check("single_busy", {7'b0, busy}, 8'h01);
        check("single_done_early", {4'b0, done}, 8'h00);
        tick(); tick();
        check("single_done_c2", {4'b0, done}, 8'h00);
        tick();
        check("single_done", {4'b0, done}, 8'h01);
        check("single_result", result, 8'hAA);
        req = 4'b0000;
        tick();
        check("single_gnt_clr", {4'b0, gnt}, 8'h00);
        check("single_done_clr", {4'b0, done}, 8'h00);
        check("single_idle", {7'b0, busy}, 8'h00);
        check("single_result_hold", result, 8'hAA);

        // Round robin with all requesters held from reset; reset beats the request
        reset = 1'b1; req = 4'b1111;
        tick();
        check("rst_prio_gnt", {4'b0, gnt}, 8'h00);
        check("rst_prio_busy", {7'b0, busy}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_gnt%0d", i), {4'b0, gnt}, {4'b0, rr_gnt[i]});
            tick(); tick(); tick();
            check($sformatf("rr_done%0d", i), {4'b0, done}, {4'b0, rr_gnt[i]});
            check($sformatf("rr_res%0d", i), result, rr_res[i]);
            if (i == 4) req = 4'b0000;
            tick();
            check($sformatf("rr_gap%0d", i), {4'b0, gnt}, 8'h00);
        end

        // Operand isolation: requester 2 operands change during SETTLE
        req = 4'b0100;
        tick();
        check("iso_gnt", {4'b0, gnt}, 8'h04);
        a2 = 8'h00;
        tick(); tick(); tick();
        check("iso_done", {4'b0, done}, 8'h04);
        check("iso_result", result, 8'hFF);
        req = 4'b0000;
        tick();

        // Reset while the counter is at 2 discards the operation
        req = 4'b0010; a1 = 8'h5A; b1 = 8'h00;
        tick();
        check("rmid_gnt", {4'b0, gnt}, 8'h02);
        tick();
        reset = 1'b1;
        tick();
        check("rmid_gnt_clr", {4'b0, gnt}, 8'h00);
        check("rmid_busy", {7'b0, busy}, 8'h00);
        check("rmid_result", result, 8'h00);
        check("rmid_done", {4'b0, done}, 8'h00);
        reset = 1'b0; req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rmid_nodone%0d", i), {4'b0, done}, 8'h00);
        end

        // Requester 3 drops its request right after the grant
        req = 4'b1000;
        tick();
        check("drop_gnt", {4'b0, gnt}, 8'h08);
        req = 4'b0000;
        tick(); tick();
        check("drop_done_early", {4'b0, done}, 8'h00);
        tick();
        check("drop_done", {4'b0, done}, 8'h08);
        check("drop_result", result, 8'h26);
        tick();
        check("drop_gnt_clr", {4'b0, gnt}, 8'h00);
        tick(); tick();
        check("drop_idle_busy", {7'b0, busy}, 8'h00);
        check("drop_idle_gnt", {4'b0, gnt}, 8'h00);

        // SETTLE=1 build: identity operands, done one cycle after grant
        a1 = 8'h3C; b1 = 8'h3C; req1 = 4'b0010;
        tick();
        check("s1_gnt", {4'b0, gnt1}, 8'h02);
        check("s1_done_early", {4'b0, done1}, 8'h00);
        tick();
        check("s1_done", {4'b0, done1}, 8'h02);
        check("s1_result", result1, 8'h00);
        req1 = 4'b0000;
        tick();
        check("s1_gnt_clr", {4'b0, gnt1}, 8'h00);
        check("s1_busy", {7'b0, busy1}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
